// File: rtl/audio_pkg.sv
// Shared types and constants for the stereo mixing engine.
package audio_pkg;

    typedef enum logic [1:0] {
        MONO  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        MUTE  = 2'd3
    } ch_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCALE = 2'd2,
        PUSH  = 2'd3
    } mix_state_e;

    localparam int unsigned UNITY_VOLUME = 128;
    localparam int unsigned VOLUME_SHIFT = 7;

endpackage

// File: rtl/stereo_fifo.sv
// First-word-fall-through frame FIFO; a push into a full FIFO succeeds only
// when a pop happens in the same cycle.
module stereo_fifo
    import audio_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     level_q, level_d;
    logic               push_ok, pop_ok;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == (PTR_W+1)'(DEPTH));
    assign level_o = level_q;
    // Empty FIFO presents zeros rather than stale storage.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/audio_mix_engine.sv
// Sequential stereo mixer: snapshots all channels on tick, accumulates one
// channel per cycle, applies master volume, saturates and queues the frame.
module audio_mix_engine
    import audio_pkg::*;
#(
    parameter int unsigned NUM_CH   = 8,
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic [NUM_CH*SAMPLE_W-1:0]   ch_sample,
    input  logic [NUM_CH*8-1:0]          ch_volume,
    input  logic [NUM_CH*2-1:0]          ch_mode,
    input  logic [7:0]                   master_volume,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SAMPLE_W-1:0]          out_left,
    output logic [SAMPLE_W-1:0]          out_right,
    output logic [$clog2(DEPTH):0]       fifo_level,
    output logic                         busy,
    output logic                         overrun,
    output logic                         tick_dropped
);

    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned ACC_W = SAMPLE_W + 2 + $clog2(NUM_CH);
    localparam int unsigned P_W   = SAMPLE_W + 9;
    localparam int unsigned SC_W  = ACC_W + 9;
    localparam logic signed [SC_W-1:0] SAT_MAX =
        {{(SC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SC_W-1:0] SAT_MIN =
        {{(SC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    mix_state_e                     state_q, state_d;
    logic [IDX_W-1:0]               ch_idx_q, ch_idx_d;
    logic                           overrun_q, overrun_d;
    logic                           tick_drop_q, tick_drop_d;

    logic [NUM_CH*SAMPLE_W-1:0]     smp_q, smp_d;
    logic [NUM_CH*8-1:0]            vol_q, vol_d;
    logic [NUM_CH*2-1:0]            mode_q, mode_d;
    logic [7:0]                     master_q, master_d;
    logic signed [ACC_W-1:0]        acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic signed [SC_W-1:0]         scl_l_q, scl_l_d, scl_r_q, scl_r_d;

    logic signed [P_W-1:0]          smp_ext, vol_ext, prod, prod_sh;
    logic signed [ACC_W-1:0]        s_acc;
    logic signed [SC_W-1:0]         accl_ext, accr_ext, mst_ext;
    ch_mode_e                       cur_mode;

    logic                           fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [2*SAMPLE_W-1:0]          fifo_wdata, fifo_rdata;

    function automatic logic [SAMPLE_W-1:0] sat(input logic signed [SC_W-1:0] v);
        if (v > SAT_MAX)      return SAT_MAX[SAMPLE_W-1:0];
        else if (v < SAT_MIN) return SAT_MIN[SAMPLE_W-1:0];
        else                  return v[SAMPLE_W-1:0];
    endfunction

    // Per-channel product: sample x {0,vol}, floored by the volume shift.
    always_comb begin
        smp_ext  = P_W'($signed(smp_q[ch_idx_q*SAMPLE_W +: SAMPLE_W]));
        vol_ext  = P_W'({1'b0, vol_q[ch_idx_q*8 +: 8]});
        prod     = smp_ext * vol_ext;
        prod_sh  = prod >>> VOLUME_SHIFT;
        s_acc    = ACC_W'(prod_sh);
        cur_mode = ch_mode_e'(mode_q[ch_idx_q*2 +: 2]);
        accl_ext = SC_W'(acc_l_q);
        accr_ext = SC_W'(acc_r_q);
        mst_ext  = SC_W'({1'b0, master_q});
    end

    always_comb begin
        state_d     = state_q;
        ch_idx_d    = ch_idx_q;
        smp_d       = smp_q;
        vol_d       = vol_q;
        mode_d      = mode_q;
        master_d    = master_q;
        acc_l_d     = acc_l_q;
        acc_r_d     = acc_r_q;
        scl_l_d     = scl_l_q;
        scl_r_d     = scl_r_q;
        tick_drop_d = tick && (state_q != IDLE);
        overrun_d   = (state_q == PUSH) && fifo_full && !fifo_pop;
        fifo_push   = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick) begin
                    smp_d    = ch_sample;
                    vol_d    = ch_volume;
                    mode_d   = ch_mode;
                    master_d = master_volume;
                    acc_l_d  = '0;
                    acc_r_d  = '0;
                    ch_idx_d = '0;
                    state_d  = ACCUM;
                end
            end
            ACCUM: begin
                if (cur_mode == MONO || cur_mode == LEFT)  acc_l_d = acc_l_q + s_acc;
                if (cur_mode == MONO || cur_mode == RIGHT) acc_r_d = acc_r_q + s_acc;
                if (ch_idx_q == IDX_W'(NUM_CH-1)) state_d = SCALE;
                else                              ch_idx_d = ch_idx_q + 1'b1;
            end
            SCALE: begin
                scl_l_d = (accl_ext * mst_ext) >>> VOLUME_SHIFT;
                scl_r_d = (accr_ext * mst_ext) >>> VOLUME_SHIFT;
                state_d = PUSH;
            end
            PUSH: begin
                fifo_push = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ch_idx_q    <= '0;
            overrun_q   <= 1'b0;
            tick_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_idx_q    <= ch_idx_d;
            overrun_q   <= overrun_d;
            tick_drop_q <= tick_drop_d;
        end
    end

    always_ff @(posedge clk) begin
        smp_q    <= smp_d;
        vol_q    <= vol_d;
        mode_q   <= mode_d;
        master_q <= master_d;
        acc_l_q  <= acc_l_d;
        acc_r_q  <= acc_r_d;
        scl_l_q  <= scl_l_d;
        scl_r_q  <= scl_r_d;
    end

    assign fifo_wdata = {sat(scl_l_q), sat(scl_r_q)};
    assign fifo_pop   = out_valid && out_ready;

    stereo_fifo #(
        .WIDTH (2*SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign out_valid    = !fifo_empty;
    assign out_left     = fifo_rdata[2*SAMPLE_W-1:SAMPLE_W];
    assign out_right    = fifo_rdata[SAMPLE_W-1:0];
    assign busy         = (state_q != IDLE);
    assign overrun      = overrun_q;
    assign tick_dropped = tick_drop_q;

endmodule

// File: tb/tb_audio_mix_engine.sv
// Directed bench for audio_mix_engine (4 channels, 4-frame FIFO).
module tb_audio_mix_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic [63:0] ch_sample;
    logic [31:0] ch_volume;
    logic [7:0]  ch_mode;
    logic [7:0]  master_volume;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_left, out_right;
    logic [2:0]  fifo_level;
    logic        busy, overrun, tick_dropped;

    int n_checks = 0;
    int n_errors = 0;
    int ovr_cnt  = 0;
    int drop_cnt = 0;

    audio_mix_engine #(
        .NUM_CH   (4),
        .SAMPLE_W (16),
        .DEPTH    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .ch_sample     (ch_sample),
        .ch_volume     (ch_volume),
        .ch_mode       (ch_mode),
        .master_volume (master_volume),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_left      (out_left),
        .out_right     (out_right),
        .fifo_level    (fifo_level),
        .busy          (busy),
        .overrun       (overrun),
        .tick_dropped  (tick_dropped)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overrun)      ovr_cnt  = ovr_cnt + 1;
        if (tick_dropped) drop_cnt = drop_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int idx, input int smp, input int vol, input int mode);
        logic [15:0] s16;
        logic [7:0]  v8;
        logic [1:0]  m2;
        s16 = smp[15:0];
        v8  = vol[7:0];
        m2  = mode[1:0];
        ch_sample[idx*16 +: 16] = s16;
        ch_volume[idx*8 +: 8]   = v8;
        ch_mode[idx*2 +: 2]     = m2;
    endtask

    task automatic mute_all();
        for (int i = 0; i < 4; i++) set_ch(i, 0, 128, 3);
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            step(1);
            n++;
        end
        check({tag, "_valid"}, int'(out_valid), 1);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
    endtask

    task automatic frame(input string tag, input int exp_l, input int exp_r);
        tick_pulse();
        wait_valid(tag);
        check({tag, "_L"}, int'($signed(out_left)), exp_l);
        check({tag, "_R"}, int'($signed(out_right)), exp_r);
        pop_one();
    endtask

    initial begin
        int ovr0, drop0;
        rst = 1'b1; tick = 1'b0; out_ready = 1'b0;
        ch_sample = '0; ch_volume = '0; ch_mode = '0; master_volume = 8'd128;
        step(3);
        rst = 1'b0;
        step(1);

        check("rst_valid", int'(out_valid), 0);
        check("rst_left", int'(out_left), 0);
        check("rst_right", int'(out_right), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_drop", int'(tick_dropped), 0);

        // Basic frame with exact latency: tick at T, valid at T+7.
        mute_all();
        set_ch(0, 1000, 128, 0);
        tick_pulse();
        check("lat_busy_T1", int'(busy), 1);
        step(5);
        check("lat_valid_T6", int'(out_valid), 0);
        step(1);
        check("lat_valid_T7", int'(out_valid), 1);
        check("lat_busy_T7", int'(busy), 0);
        check("lat_level", int'(fifo_level), 1);
        check("basic_L", int'($signed(out_left)), 1000);
        check("basic_R", int'($signed(out_right)), 1000);
        pop_one();
        check("pop_level", int'(fifo_level), 0);

        // Saturation.
        for (int i = 0; i < 4; i++) set_ch(i, 30000, 128, 0);
        frame("sat_pos", 32767, 32767);
        for (int i = 0; i < 4; i++) set_ch(i, -30000, 128, 0);
        frame("sat_neg", -32768, -32768);

        // Volume and floor rounding.
        mute_all();
        set_ch(0, -1000, 64, 0);
        frame("vol64", -500, -500);
        set_ch(0, -1, 1, 0);
        frame("floor", -1, -1);
        set_ch(0, 1, 255, 0);
        frame("vol255", 1, 1);
        set_ch(0, 1000, 128, 0);
        master_volume = 8'd64;
        frame("master64", 500, 500);
        master_volume = 8'd128;

        // Routing.
        set_ch(0, 100, 128, 1);
        set_ch(1, 200, 128, 2);
        set_ch(2, 5000, 128, 3);
        set_ch(3, -50, 128, 0);
        frame("route", 50, 150);

        // Full FIFO: fifth frame dropped, overrun once, order preserved.
        mute_all();
        ovr0 = ovr_cnt;
        for (int k = 1; k <= 5; k++) begin
            set_ch(0, k * 100, 128, 0);
            tick_pulse();
            step(9);
        end
        check("full_level", int'(fifo_level), 4);
        check("full_ovr_cnt", ovr_cnt - ovr0, 1);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("drain1_f%0d", k), int'($signed(out_left)), k * 100);
            step(1);
        end
        out_ready = 1'b0;
        check("drain1_empty", int'(out_valid), 0);

        // Full FIFO with a pop coinciding with PUSH: frame accepted.
        for (int k = 1; k <= 4; k++) begin
            set_ch(0, k * 100, 128, 0);
            tick_pulse();
            step(9);
        end
        ovr0 = ovr_cnt;
        set_ch(0, 500, 128, 0);
        tick_pulse();
        step(5);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        step(2);
        check("pp_level", int'(fifo_level), 4);
        check("pp_ovr_cnt", ovr_cnt - ovr0, 0);
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            check($sformatf("drain2_f%0d", k), int'($signed(out_left)), k * 100);
            step(1);
        end
        out_ready = 1'b0;
        check("drain2_empty", int'(out_valid), 0);

        // Tick while busy is dropped.
        drop0 = drop_cnt;
        set_ch(0, 700, 128, 0);
        tick_pulse();
        step(1);
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        check("drop_pulse", int'(tick_dropped), 1);
        step(10);
        check("drop_level", int'(fifo_level), 1);
        check("drop_cnt", drop_cnt - drop0, 1);
        check("drop_L", int'($signed(out_left)), 700);
        pop_one();

        // Reset mid-ACCUM aborts the frame.
        set_ch(0, 900, 128, 0);
        tick_pulse();
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mrst_busy", int'(busy), 0);
        check("mrst_valid", int'(out_valid), 0);
        check("mrst_left", int'(out_left), 0);
        check("mrst_right", int'(out_right), 0);
        check("mrst_ovr", int'(overrun), 0);
        check("mrst_drop", int'(tick_dropped), 0);
        step(10);
        check("mrst_level", int'(fifo_level), 0);
        set_ch(0, 1000, 128, 0);
        frame("post_rst", 1000, 1000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
